// File: rtl/shift_scheduler.sv
// shift_scheduler: frame-aligned shift amount sequencer with table playback and linear sweep.
// Shift changes only land one cycle after a frame_sync so the shifter never switches mid-frame.
module shift_scheduler #(
    parameter int TABLE_DEPTH = 16,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr_en,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [7:0]        cfg_data,
    input  logic              mode,
    input  logic [ADDR_W:0]   table_len,
    input  logic              loop_en,
    input  logic [7:0]        sweep_start,
    input  logic [7:0]        sweep_end,
    input  logic [7:0]        sweep_step,
    input  logic [7:0]        hold_frames,
    input  logic              start,
    input  logic              stop,
    input  logic              frame_sync,
    output logic [7:0]        shift_amt,
    output logic              shift_update,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, ARM, HOLD, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(TABLE_DEPTH);

    state_t            state, state_n;
    logic [7:0]        tbl [TABLE_DEPTH];
    logic              mode_l, loop_l;
    logic [ADDR_W:0]   len_l;
    logic [7:0]        sw_start_l, sw_end_l, sw_step_l, hold_l;
    logic [7:0]        frame_cnt, cnt_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic              ld, latch;
    logic [7:0]        ld_val;
    logic [7:0]        hold1, step1;
    logic [8:0]        nxt;
    logic [ADDR_W:0]   idx_inc;
    logic              start_ok, idle_like;

    assign idle_like = state == IDLE || state == DONE;
    assign start_ok  = mode || (table_len != '0 && table_len <= DEPTH);
    assign hold1     = hold_l == 8'd0 ? 8'd1 : hold_l;
    assign step1     = sw_step_l == 8'd0 ? 8'd1 : sw_step_l;
    assign nxt       = {1'b0, shift_amt} + {1'b0, step1};
    assign idx_inc   = {1'b0, idx} + (ADDR_W + 1)'(1);
    assign busy      = state == ARM || state == HOLD;
    assign done      = state == DONE;

    always_comb begin
        state_n = state;
        cnt_n   = frame_cnt;
        idx_n   = idx;
        ld      = 1'b0;
        ld_val  = shift_amt;
        latch   = 1'b0;
        if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && start_ok) begin
                        latch   = 1'b1;
                        state_n = ARM;
                    end
                end
                ARM: begin
                    if (frame_sync) begin
                        ld      = 1'b1;
                        ld_val  = mode_l ? sw_start_l : tbl[0];
                        idx_n   = '0;
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (frame_sync) begin
                        if (frame_cnt > 8'd1) begin
                            cnt_n = frame_cnt - 8'd1;
                        end else if (mode_l) begin
                            ld      = nxt <= {1'b0, sw_end_l};
                            ld_val  = nxt[7:0];
                            state_n = ld ? HOLD : DONE;
                        end else if (idx_inc < len_l) begin
                            ld     = 1'b1;
                            ld_val = tbl[idx_inc[ADDR_W-1:0]];
                            idx_n  = idx_inc[ADDR_W-1:0];
                        end else if (loop_l) begin
                            ld     = 1'b1;
                            ld_val = tbl[0];
                            idx_n  = '0;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (ld) cnt_n = hold1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            idx          <= '0;
            shift_amt    <= '0;
            shift_update <= 1'b0;
            mode_l       <= 1'b0;
            loop_l       <= 1'b0;
            len_l        <= '0;
            sw_start_l   <= '0;
            sw_end_l     <= '0;
            sw_step_l    <= '0;
            hold_l       <= '0;
        end else begin
            state        <= state_n;
            frame_cnt    <= cnt_n;
            idx          <= idx_n;
            shift_update <= ld;
            if (ld) shift_amt <= ld_val;
            if (latch) begin
                mode_l     <= mode;
                loop_l     <= loop_en;
                len_l      <= table_len;
                sw_start_l <= sweep_start;
                sw_end_l   <= sweep_end;
                sw_step_l  <= sweep_step;
                hold_l     <= hold_frames;
            end
        end
    end

    // Table is only writable while no sequence is reading it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) tbl[i] <= '0;
        end else if (cfg_wr_en && idle_like) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end
endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: directed checks of table playback, sweep, stop, and reset behaviour.
module tb_shift_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_wr_en;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       mode;
    logic [4:0] table_len;
    logic       loop_en;
    logic [7:0] sweep_start, sweep_end, sweep_step, hold_frames;
    logic       start, stop, frame_sync;
    logic [7:0] shift_amt;
    logic       shift_update, busy, done;
    int         total = 0;
    int         bad = 0;
    int         upd_cnt = 0;
    int         upd0;

    shift_scheduler #(.TABLE_DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .mode(mode), .table_len(table_len), .loop_en(loop_en), .sweep_start(sweep_start),
        .sweep_end(sweep_end), .sweep_step(sweep_step), .hold_frames(hold_frames),
        .start(start), .stop(stop), .frame_sync(frame_sync), .shift_amt(shift_amt),
        .shift_update(shift_update), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (shift_update) upd_cnt <= upd_cnt + 1;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic frame();
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic frame_chk(input string tag, input int unsigned amt, input int unsigned upd);
        frame();
        chk({tag, "_amt"}, shift_amt, amt);
        chk({tag, "_upd"}, shift_update, upd);
    endtask

    task automatic cfg(input logic m, input logic [4:0] len, input logic lp, input logic [7:0] hf);
        mode = m; table_len = len; loop_en = lp; hold_frames = hf;
    endtask

    initial begin
        rst = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0;
        mode = 1'b0; table_len = '0; loop_en = 1'b0;
        sweep_start = '0; sweep_end = '0; sweep_step = '0; hold_frames = '0;
        start = 1'b0; stop = 1'b0; frame_sync = 1'b0;
        repeat (3) tick();
        chk("rst_amt", shift_amt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        tick();
        frame(); frame();
        chk("idle_no_upd", upd_cnt, 0);

        wr(0, 5); wr(1, 9); wr(2, 200);
        cfg(0, 3, 0, 2);
        upd0 = upd_cnt;
        pulse_start();
        chk("t_busy", busy, 1);
        frame_chk("t_f1", 5, 1);
        tick();
        chk("t_f1_pulse_end", shift_update, 0);
        frame_chk("t_f2", 5, 0);
        frame_chk("t_f3", 9, 1);
        frame_chk("t_f4", 9, 0);
        frame_chk("t_f5", 200, 1);
        frame_chk("t_f6", 200, 0);
        frame_chk("t_f7", 200, 0);
        chk("t_done", done, 1);
        chk("t_busy_end", busy, 0);
        tick();
        chk("t_upd_count", upd_cnt - upd0, 3);

        cfg(0, 3, 1, 0);
        pulse_start();
        chk("l_done_clr", done, 0);
        frame_chk("l_f1", 5, 1);
        frame_chk("l_f2", 9, 1);
        frame_chk("l_f3", 200, 1);
        frame_chk("l_f4", 5, 1);
        frame_chk("l_f5", 9, 1);
        chk("l_busy", busy, 1);
        chk("l_done", done, 0);

        stop = 1'b1; frame_sync = 1'b1;
        tick();
        stop = 1'b0; frame_sync = 1'b0;
        chk("stop_amt", shift_amt, 9);
        chk("stop_upd", shift_update, 0);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        cfg(0, 0, 0, 1);
        pulse_start();
        chk("len0_busy", busy, 0);
        cfg(0, 17, 0, 1);
        pulse_start();
        chk("len17_busy", busy, 0);

        cfg(1, 0, 0, 1);
        sweep_start = 250; sweep_end = 255; sweep_step = 4;
        pulse_start();
        frame_chk("s_f1", 250, 1);
        frame_chk("s_f2", 254, 1);
        frame_chk("s_f3", 254, 0);
        chk("s_done", done, 1);

        wr(0, 33);
        cfg(0, 3, 0, 1);
        start = 1'b1; frame_sync = 1'b1;
        tick();
        start = 1'b0; frame_sync = 1'b0;
        chk("sf_busy", busy, 1);
        chk("sf_upd", shift_update, 0);
        chk("sf_amt", shift_amt, 254);
        wr(0, 77);
        frame_chk("busywr_f1", 33, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        cfg(1, 0, 0, 2);
        sweep_start = 100; sweep_end = 50; sweep_step = 3;
        pulse_start();
        frame_chk("rev_f1", 100, 1);
        frame_chk("rev_f2", 100, 0);
        frame_chk("rev_f3", 100, 0);
        chk("rev_done", done, 1);

        cfg(0, 3, 0, 1);
        pulse_start();
        frame_chk("pre_rst", 33, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_amt", shift_amt, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst = 1'b1;
        cfg(0, 2, 0, 1);
        wr(1, 0);
        pulse_start();
        frame_chk("clr_f1", 0, 1);
        wr(2, 44);
        frame_chk("clr_f2", 0, 1);
        frame_chk("clr_f3", 0, 0);
        chk("clr_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
